// File: rtl/camera_ex_ctrl_n.sv
// ---------------------------------------------------------------------------
// camera_ex_ctrl_n
//
// Exposure/readout sequencer for the pixel-array camera. It erases the array
// while idle, exposes for a latched number of cycles, then reads out ROWS
// rows. Each row takes four cycles: select, convert, hold and release. The
// block supports single-shot capture, continuous capture (auto-restart after
// one erase cycle) and a synchronous abort back to idle.
//
// Parameters
//   ROWS       number of pixel rows read out (>= 1)
//   EXP_W      width of the exposure-time input and counter
//
// Ports
//   Clk        clock, rising edge
//   Reset      synchronous, active-high; highest priority
//   Init       start a frame (only looked at while idle)
//   Continuous restart automatically after readout
//   Abort      synchronous abort to idle; beats Init and Continuous
//   ExpTime    exposure length in cycles, latched at frame start (0 acts as 1)
//   Erase      pixel erase, high while idle
//   Expose     pixel exposure, high during exposure
//   Start      exposure-timer start indication, high during exposure
//   ADC        ADC convert strobe
//   NRE        per-row read enable, active-low, at most one bit low
//   Busy       high during exposure and readout
//   FrameDone  one-cycle pulse in the last readout cycle
//
// Every output is a flop loaded from the next-state decode, so none of them
// has a combinational path from an input.
// ---------------------------------------------------------------------------
module camera_ex_ctrl_n #(
    parameter int unsigned ROWS  = 2,
    parameter int unsigned EXP_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Continuous,
    input  logic             Abort,
    input  logic [EXP_W-1:0] ExpTime,
    output logic             Erase,
    output logic             Expose,
    output logic             Start,
    output logic             ADC,
    output logic [ROWS-1:0]  NRE,
    output logic             Busy,
    output logic             FrameDone
);

    localparam int unsigned      RowW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RowW-1:0]  LastRow = RowW'(ROWS - 1);
    localparam logic [RowW-1:0]  RowOne  = RowW'(1);
    localparam logic [EXP_W-1:0] ExpOne  = EXP_W'(1);

    // Row phases: select, convert, hold, release.
    localparam logic [1:0] PhConvert = 2'd1;
    localparam logic [1:0] PhRelease = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StExpose,
        StRead
    } state_e;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [1:0]       phase_q, phase_d;
    logic             restart_q, restart_d;

    // -----------------------------------------------------------------------
    // Output registers and their next values
    // -----------------------------------------------------------------------
    logic            erase_q, erase_d;
    logic            expose_q, expose_d;
    logic            start_q, start_d;
    logic            adc_q, adc_d;
    logic [ROWS-1:0] nre_q, nre_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        row_d     = row_q;
        phase_d   = phase_q;
        restart_d = restart_q;

        if (Abort) begin
            state_d   = StIdle;
            exp_cnt_d = '0;
            row_d     = '0;
            phase_d   = '0;
            restart_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Init || restart_q) begin
                        state_d   = StExpose;
                        // A zero exposure still spends one cycle exposing.
                        exp_cnt_d = (ExpTime == '0) ? ExpOne : ExpTime;
                        restart_d = 1'b0;
                    end
                end

                StExpose: begin
                    // Terminal count is 1; the counter stops here, never wraps.
                    if (exp_cnt_q <= ExpOne) begin
                        state_d   = StRead;
                        exp_cnt_d = '0;
                        row_d     = '0;
                        phase_d   = '0;
                    end else begin
                        exp_cnt_d = exp_cnt_q - ExpOne;
                    end
                end

                StRead: begin
                    if (phase_q == PhRelease) begin
                        phase_d = '0;
                        if (row_q == LastRow) begin
                            state_d   = StIdle;
                            row_d     = '0;
                            restart_d = Continuous;
                        end else begin
                            row_d = row_q + RowOne;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end

                default: begin
                    state_d   = StIdle;
                    exp_cnt_d = '0;
                    row_d     = '0;
                    phase_d   = '0;
                    restart_d = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode of the next state, registered below
    // -----------------------------------------------------------------------
    always_comb begin
        erase_d      = (state_d == StIdle);
        expose_d     = (state_d == StExpose);
        start_d      = (state_d == StExpose);
        busy_d       = (state_d != StIdle);
        adc_d        = (state_d == StRead) && (phase_d == PhConvert);
        frame_done_d = (state_d == StRead) && (row_d == LastRow) && (phase_d == PhRelease);

        nre_d = '1;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if ((state_d == StRead) && (phase_d != PhRelease) && (row_d == RowW'(i))) begin
                nre_d[i] = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state and outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            exp_cnt_q    <= '0;
            row_q        <= '0;
            phase_q      <= '0;
            restart_q    <= 1'b0;
            erase_q      <= 1'b1;
            expose_q     <= 1'b0;
            start_q      <= 1'b0;
            adc_q        <= 1'b0;
            nre_q        <= '1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_cnt_q    <= exp_cnt_d;
            row_q        <= row_d;
            phase_q      <= phase_d;
            restart_q    <= restart_d;
            erase_q      <= erase_d;
            expose_q     <= expose_d;
            start_q      <= start_d;
            adc_q        <= adc_d;
            nre_q        <= nre_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Erase     = erase_q;
    assign Expose    = expose_q;
    assign Start     = start_q;
    assign ADC       = adc_q;
    assign NRE       = nre_q;
    assign Busy      = busy_q;
    assign FrameDone = frame_done_q;

endmodule

// File: doc/camera_ex_ctrl_n.md
# camera_ex_ctrl_n

Parametrised exposure/readout controller for the pixel-array camera. It sequences erase, exposure and row-by-row readout for `ROWS` pixel rows, each with its own active-low read-enable. Exposure length is counted internally from a latched `ExpTime` value rather than taken from an external overflow strobe. The block adds single-shot and continuous capture modes plus a synchronous abort, and sits between the top-level camera control and the pixel array/ADC.

## Interface
- `ROWS`, default 2: number of pixel rows read out, ≥1.
- `EXP_W`, default 5: width of the exposure-time input and counter.
- `Clk`  input  1: clock; all logic on the rising edge.
- `Reset`  input  1: synchronous, active-high.
- `Init`  input  1: start a frame; sampled only in IDLE.
- `Continuous`  input  1: 1 = automatically start the next frame after readout.
- `Abort`  input  1: synchronous abort; returns to IDLE from any state.
- `ExpTime`  input  EXP_W: exposure length in cycles; latched when `Init` is accepted.
- `Erase`  output  1: pixel erase; high only in IDLE.
- `Expose`  output  1: pixel exposure; high in EXPOSE.
- `Start`  output  1: exposure-timer start indication; high in EXPOSE.
- `ADC`  output  1: ADC convert strobe.
- `NRE`  output  ROWS: per-row read enable, active-low.
- `Busy`  output  1: high in EXPOSE and READ.
- `FrameDone`  output  1: one-cycle pulse in the last readout cycle.

## Operation
- All outputs are registered and are a pure function of the state registers; there are no combinational paths from inputs to outputs.
- States and their output values:
  - **IDLE**: `Erase`=1, `Expose`=0, `Start`=0, `ADC`=0, `NRE`=all 1, `Busy`=0.
  - **EXPOSE**: `Erase`=0, `Expose`=1, `Start`=1, `Busy`=1, `NRE`=all 1, `ADC`=0.
  - **READ**: `Erase`=0, `Expose`=0, `Start`=0, `Busy`=1; `ADC` and `NRE` are driven by the readout phase.
- IDLE → EXPOSE:
  - Taken when `Init`=1, or when the auto-restart flag is set.
  - On the transition, the exposure counter loads `ExpTime`; `ExpTime`=0 is treated as 1.
- EXPOSE → READ when the counter reaches its terminal count. The counter is EXP_W bits, decrements, and never wraps.
- READ iterates row index r = 0 … ROWS-1. Each row takes 4 phases:
  - Phase 0: `NRE[r]`=0, `ADC`=0.
  - Phase 1: `NRE[r]`=0, `ADC`=1.
  - Phase 2: `NRE[r]`=0, `ADC`=0.
  - Phase 3: `NRE[r]`=1, `ADC`=0.
- At most one `NRE` bit is low at any time, and `ADC`=1 only while exactly one `NRE` bit is low.
- After phase 3 of row ROWS-1:
  - `FrameDone`=1 during that cycle.
  - Next state is IDLE.
  - The auto-restart flag is set to the `Continuous` value sampled in that cycle.
- Auto-restart: IDLE lasts exactly 1 cycle (`Erase`=1), then EXPOSE starts using the `ExpTime` value present in that IDLE cycle. The flag clears on entering EXPOSE.
- `Init` is ignored outside IDLE.
- `Abort`=1 in any state:
  - Next state is IDLE, with all outputs at IDLE values.
  - The row index, phase and exposure counter clear, and the auto-restart flag clears.
  - `FrameDone` is not pulsed.
  - `Abort` has priority over `Init` and `Continuous`.
- `Reset` has priority over everything and yields the IDLE output values on the next edge, including mid-exposure or mid-readout.

## Timing
- Reset values: `Erase`=1, `Expose`=0, `Start`=0, `ADC`=0, `NRE`={ROWS{1}}, `Busy`=0, `FrameDone`=0; state IDLE, all counters 0, auto-restart flag 0.
- Latency:
  - `Init` sampled high at edge k → `Expose`=1 from edge k+1.
  - EXPOSE lasts E = max(`ExpTime`,1) cycles.
  - READ lasts 4·ROWS cycles.
  - `FrameDone` falls and IDLE is entered at edge k+1+E+4·ROWS.
- Single frame: total `Busy` time is E+4·ROWS cycles.
- Continuous frame period: E+4·ROWS+1 cycles, because of the one IDLE/erase cycle between frames.
- `Init` held high continuously in single mode: a new frame starts after each 1-cycle IDLE, giving the same period as continuous mode.
- `Abort` sampled at edge j → IDLE outputs from edge j+1.
- Row phase counter is 2 bits; row index is clog2(ROWS) bits (minimum 1) and never exceeds ROWS-1.

## Test plan
- **Reset check:** apply `Reset` for 2 cycles → `Erase`=1, `NRE`=2'b11, all other outputs 0; holding `Init`=1 during `Reset` does not start a frame.
- **Single frame** (ROWS=2, `ExpTime`=5): pulse `Init` for 1 cycle.
  - `Expose`=1 for exactly 5 cycles.
  - Then `NRE`=10,10,10,11,01,01,01,11 over 8 cycles, with `ADC`=1 only in the 2nd and 6th of these.
  - `FrameDone` high in the 8th cycle, then IDLE.
- **Zero exposure:** `ExpTime`=0 → `Expose` high for exactly 1 cycle; the rest of the frame matches the single-frame case.
- **Continuous mode** (`Continuous`=1, `ExpTime`=3, ROWS=2): `Expose` rises every 12 cycles, with exactly one `Erase`=1 cycle between frames. Dropping `Continuous` before a `FrameDone` stops capture after that frame.
- **Abort:**
  - Abort in the 3rd readout cycle → next cycle IDLE values (`NRE`=11, `ADC`=0, `Erase`=1), no `FrameDone`, no restart even with `Continuous`=1.
  - Abort mid-exposure behaves the same.
- **Parameter sweep:** ROWS=1,3,8 and EXP_W=3,8 with `ExpTime` at max (7 and 255) → `Busy` length = `ExpTime`+4·ROWS, no counter wrap, at most one `NRE` bit low at any time.
